// File: rtl/sd_cmd_sequencer.sv
// SD SPI command sequencer: CRC7 request, 48-bit command frame out, R1 poll.
// Optional macro SDCMD_R7_EN adds RESP_EXT, clocking 4 trailing bytes into resp_ext.
module sd_cmd_sequencer #(
  parameter int CLK_DIV     = 4,
  parameter int NCR_MAX     = 8,
  parameter int CRC_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        resp_timeout,
  output logic        busy,
  output logic [39:0] crc_in,
  output logic        crc_start,
  input  logic [6:0]  crc_out,
  input  logic        crc_rdy,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
  localparam int CRC_W  = (CRC_TIMEOUT > 0) ? $clog2(CRC_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CRC_REQ, S_CRC_WAIT, S_SEND, S_RESP_WAIT,
`ifdef SDCMD_R7_EN
    S_RESP_EXT,
`endif
    S_TRAIL, S_DONE
  } state_t;

  state_t            r_state;
  logic [5:0]        r_index;
  logic [31:0]       r_arg;
  logic [46:0]       r_frame;
  logic [7:0]        r_rx;
  logic [7:0]        r_r1;
  logic              r_to;
  logic [DIV_W-1:0]  r_div;
  logic [5:0]        r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic [CRC_W-1:0]  r_crc_cnt;
  logic              r_sck, r_mosi, r_cs_n, r_crc_start;
  logic              r_resp_valid, r_resp_timeout;
  logic [7:0]        r_resp_r1;
  logic              w_shifting, w_tick, w_rise, w_fall;
  logic [47:0]       w_frame;

  assign w_frame = {2'b01, r_index, r_arg, crc_out, 1'b1};
  assign w_tick  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise  = w_shifting && w_tick && !r_sck;
  assign w_fall  = w_shifting && w_tick && r_sck;

`ifdef SDCMD_R7_EN
  logic [31:0] r_ext_sh;
  logic [31:0] r_resp_ext;
  assign w_shifting = (r_state == S_SEND) || (r_state == S_RESP_WAIT) ||
                      (r_state == S_RESP_EXT) || (r_state == S_TRAIL);
  assign resp_ext = r_resp_ext;
`else
  assign w_shifting = (r_state == S_SEND) || (r_state == S_RESP_WAIT) ||
                      (r_state == S_TRAIL);
  assign resp_ext = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;     r_index <= '0;       r_arg <= '0;
      r_frame <= '0;         r_rx <= 8'hFF;       r_r1 <= 8'hFF;
      r_to <= 1'b0;          r_div <= '0;         r_bit <= '0;
      r_byte <= '0;          r_crc_cnt <= '0;     r_sck <= 1'b0;
      r_mosi <= 1'b1;        r_cs_n <= 1'b1;      r_crc_start <= 1'b0;
      r_resp_valid <= 1'b0;  r_resp_timeout <= 1'b0; r_resp_r1 <= 8'hFF;
`ifdef SDCMD_R7_EN
      r_ext_sh <= '0;        r_resp_ext <= '0;
`endif
    end else begin
      r_crc_start  <= 1'b0;
      r_resp_valid <= 1'b0;
      // One free-running bit timer shared by every shifting state: low half, then high half.
      if (w_shifting) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) r_sck <= !r_sck;
      end
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_index     <= cmd_index;
          r_arg       <= cmd_arg;
          r_r1        <= 8'hFF;
          r_to        <= 1'b0;
          r_crc_cnt   <= '0;
          r_crc_start <= 1'b1;
`ifdef SDCMD_R7_EN
          r_ext_sh    <= '0;
`endif
          r_state     <= S_CRC_REQ;
        end
        S_CRC_REQ: r_state <= S_CRC_WAIT;
        S_CRC_WAIT: begin
          if (crc_rdy) begin
            r_frame <= w_frame[46:0];
            r_mosi  <= w_frame[47];
            r_cs_n  <= 1'b0;
            r_sck   <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_SEND;
          end else if (r_crc_cnt == CRC_W'(CRC_TIMEOUT)) begin
            r_resp_valid   <= 1'b1;
            r_resp_timeout <= 1'b1;
            r_resp_r1      <= 8'hFF;
`ifdef SDCMD_R7_EN
            r_resp_ext     <= '0;
`endif
            r_state        <= S_DONE;
          end else begin
            r_crc_cnt <= r_crc_cnt + CRC_W'(1);
          end
        end
        S_SEND: if (w_fall) begin
          if (r_bit == 6'd47) begin
            r_mosi  <= 1'b1;
            r_bit   <= '0;
            r_byte  <= '0;
            r_state <= S_RESP_WAIT;
          end else begin
            r_mosi  <= r_frame[46];
            r_frame <= {r_frame[45:0], 1'b1};
            r_bit   <= r_bit + 6'd1;
          end
        end
        S_RESP_WAIT: begin
          if (w_rise) r_rx <= {r_rx[6:0], spi_miso};
          if (w_fall) begin
            r_bit <= (r_bit == 6'd7) ? 6'd0 : r_bit + 6'd1;
            // R1 is byte aligned to the end of the command; its MSB is always 0.
            if (r_bit == 6'd7) begin
              if (!r_rx[7]) begin
                r_r1 <= r_rx;
`ifdef SDCMD_R7_EN
                r_state <= S_RESP_EXT;
`else
                r_state <= S_TRAIL;
`endif
              end else if (r_byte == BYTE_W'(NCR_MAX - 1)) begin
                r_r1    <= 8'hFF;
                r_to    <= 1'b1;
                r_state <= S_TRAIL;
              end else begin
                r_byte <= r_byte + BYTE_W'(1);
              end
            end
          end
        end
`ifdef SDCMD_R7_EN
        S_RESP_EXT: begin
          if (w_rise) r_ext_sh <= {r_ext_sh[30:0], spi_miso};
          if (w_fall) begin
            r_bit <= (r_bit == 6'd31) ? 6'd0 : r_bit + 6'd1;
            if (r_bit == 6'd31) r_state <= S_TRAIL;
          end
        end
`endif
        S_TRAIL: if (w_fall) begin
          if (r_bit == 6'd7) begin
            r_cs_n         <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_resp_r1      <= r_r1;
            r_resp_timeout <= r_to;
`ifdef SDCMD_R7_EN
            r_resp_ext     <= r_ext_sh;
`endif
            r_state        <= S_DONE;
          end else begin
            r_bit <= r_bit + 6'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign crc_in       = {2'b01, r_index, r_arg};
  assign crc_start    = r_crc_start;
  assign resp_valid   = r_resp_valid;
  assign resp_r1      = r_resp_r1;
  assign resp_timeout = r_resp_timeout;
  assign spi_sck      = r_sck;
  assign spi_mosi     = r_mosi;
  assign spi_cs_n     = r_cs_n;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a CLK_DIV=4 instance for frame/response
// checks and a CLK_DIV=1 instance for fast-SCK timing and stray crc_rdy pulses.
module tb_sd_cmd_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, cmd_ready, resp_valid, resp_timeout, busy;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg, resp_ext;
  logic [7:0]  resp_r1;
  logic [39:0] crc_in;
  logic        crc_start, crc_rdy, spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic [6:0]  crc_out;

  logic        cmd_valid_1, cmd_ready_1, resp_valid_1, resp_timeout_1, busy_1;
  logic [5:0]  cmd_index_1;
  logic [31:0] cmd_arg_1, resp_ext_1;
  logic [7:0]  resp_r1_1;
  logic [39:0] crc_in_1;
  logic        crc_start_1, crc_rdy_1, spi_sck_1, spi_mosi_1, spi_miso_1, spi_cs_n_1;
  logic [6:0]  crc_out_1;
  assign spi_miso_1 = 1'b1;

  sd_cmd_sequencer u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_valid(resp_valid),
    .resp_r1(resp_r1), .resp_ext(resp_ext), .resp_timeout(resp_timeout),
    .busy(busy), .crc_in(crc_in), .crc_start(crc_start), .crc_out(crc_out),
    .crc_rdy(crc_rdy), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  sd_cmd_sequencer #(.CLK_DIV(1), .NCR_MAX(2), .CRC_TIMEOUT(63)) u_dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_index(cmd_index_1), .cmd_arg(cmd_arg_1), .resp_valid(resp_valid_1),
    .resp_r1(resp_r1_1), .resp_ext(resp_ext_1), .resp_timeout(resp_timeout_1),
    .busy(busy_1), .crc_in(crc_in_1), .crc_start(crc_start_1), .crc_out(crc_out_1),
    .crc_rdy(crc_rdy_1), .spi_sck(spi_sck_1), .spi_mosi(spi_mosi_1),
    .spi_miso(spi_miso_1), .spi_cs_n(spi_cs_n_1)
  );

`ifdef SDCMD_R7_EN
  localparam int EXT_BITS = 32;
`else
  localparam int EXT_BITS = 0;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  logic miso_stream [0:255];
  logic mosi_log    [0:4095];
  int   base = 0;
  int   rise_cnt = 0, cs_low_cnt = 0, rv_cnt = 0, k = 0;
  int   rise_cnt_1 = 0, cs_low_1 = 0, starts_1 = 0;
  logic prev_sck = 1'b0, prev_sck_1 = 1'b0;

  logic [47:0] got_frame;
  logic [7:0]  got_r1;
  logic [31:0] got_ext;
  logic        got_to, got_cs_rv;
  int          got_lat, got_rises, got_cs_low, got_pulses, got_ones;

  // Pin monitor: SCK rising edges, MOSI per bit, cs_n-low cycles, resp_valid pulses, MISO drive.
  always @(negedge clk) begin
    if (spi_sck && !prev_sck) begin
      mosi_log[rise_cnt % 4096] = spi_mosi;
      rise_cnt = rise_cnt + 1;
    end
    prev_sck = spi_sck;
    if (!spi_cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (resp_valid) rv_cnt = rv_cnt + 1;
    k = rise_cnt - base;
    spi_miso = (k >= 0 && k < 256) ? miso_stream[k] : 1'b1;
    if (spi_sck_1 && !prev_sck_1) rise_cnt_1 = rise_cnt_1 + 1;
    prev_sck_1 = spi_sck_1;
    if (!spi_cs_n_1) cs_low_1 = cs_low_1 + 1;
    if (crc_start_1) starts_1 = starts_1 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stream();
    for (int i = 0; i < 256; i++) miso_stream[i] = 1'b1;
  endtask

  // Response byte n follows the 48 command bits, MSB first.
  task automatic set_byte(input int n, input logic [7:0] b);
    for (int i = 0; i < 8; i++) miso_stream[48 + 8*n + i] = b[7-i];
  endtask

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic give_crc, input logic [6:0] crc);
    int lat, c0, v0;
    @(posedge clk);
    base = rise_cnt; c0 = cs_low_cnt; v0 = rv_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg;
    lat = 0;
    while (crc_start !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    cmd_valid = 1'b0;
    check_eq({name, "_crc_start"}, 64'(crc_start), 64'd1);
    check_eq({name, "_crc_in"}, 64'(crc_in), 64'({2'b01, idx, arg}));
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 4000) begin
      @(negedge clk); lat++;
      crc_rdy = give_crc && (lat == 2);
      crc_out = (lat == 2) ? crc : 7'h55;
    end
    crc_rdy = 1'b0;
    check_eq({name, "_resp_valid"}, 64'(resp_valid), 64'd1);
    check_eq({name, "_crc_in_held"}, 64'(crc_in), 64'({2'b01, idx, arg}));
    got_lat = lat; got_r1 = resp_r1; got_to = resp_timeout; got_ext = resp_ext;
    got_cs_rv = spi_cs_n;
    @(negedge clk);
    check_eq({name, "_rv_single"}, 64'(resp_valid), 64'd0);
    check_eq({name, "_ready_after"}, 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    got_rises  = rise_cnt - base;
    got_cs_low = cs_low_cnt - c0;
    got_pulses = rv_cnt - v0;
    got_frame  = '0;
    got_ones   = 0;
    for (int i = 0; i < 48; i++) got_frame = {got_frame[46:0], mosi_log[(base + i) % 4096]};
    for (int i = 48; i < got_rises; i++) got_ones += int'(mosi_log[(base + i) % 4096]);
    $display("txn %s r1=%02h timeout=%0d ext=%08h sck=%0d cs_low=%0d frame=%012h",
             name, got_r1, got_to, got_ext, got_rises, got_cs_low, got_frame);
  endtask

  initial begin
    int n, s;
    rst = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; crc_rdy = 1'b0; crc_out = '0;
    cmd_valid_1 = 1'b0; cmd_index_1 = '0; cmd_arg_1 = '0; crc_rdy_1 = 1'b0; crc_out_1 = '0;
    clear_stream();
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", 64'(spi_cs_n), 64'd1);
    check_eq("rst_sck", 64'(spi_sck), 64'd0);
    check_eq("rst_mosi", 64'(spi_mosi), 64'd1);
    check_eq("rst_ready_busy", 64'({cmd_ready, busy}), 64'b10);
    check_eq("rst_resp", 64'({resp_valid, resp_timeout, resp_r1}), 64'h0FF);
    check_eq("rst_ext", 64'(resp_ext), 64'd0);
    check_eq("rst_crc_start", 64'(crc_start), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // CMD0: one 0xFF filler, then R1=0x01.
    clear_stream(); set_byte(0, 8'hFF); set_byte(1, 8'h01);
    run_cmd("cmd0", 6'd0, 32'h0, 1'b1, 7'h4A);
    check_eq("cmd0_frame", 64'(got_frame), 64'h400000000095);
    check_eq("cmd0_r1", 64'({got_to, got_r1}), 64'h001);
    check_eq("cmd0_sck", 64'(got_rises), 64'(72 + EXT_BITS));
    check_eq("cmd0_cs_low", 64'(got_cs_low), 64'(8 * (72 + EXT_BITS)));
    check_eq("cmd0_mosi_idle", 64'(got_ones), 64'(got_rises - 48));
    check_eq("cmd0_pulses", 64'(got_pulses), 64'd1);

    // CMD8: R1=0x01 immediately, then 00 00 01 AA.
    clear_stream(); set_byte(0, 8'h01); set_byte(1, 8'h00); set_byte(2, 8'h00);
    set_byte(3, 8'h01); set_byte(4, 8'hAA);
    run_cmd("cmd8", 6'd8, 32'h1AA, 1'b1, 7'h43);
    check_eq("cmd8_frame", 64'(got_frame), 64'h48000001AA87);
    check_eq("cmd8_r1", 64'({got_to, got_r1}), 64'h001);
    check_eq("cmd8_sck", 64'(got_rises), 64'(64 + EXT_BITS));
`ifdef SDCMD_R7_EN
    check_eq("cmd8_ext", 64'(got_ext), 64'h000001AA);
`else
    check_eq("cmd8_ext", 64'(got_ext), 64'h0);
`endif

    // CMD17 with MISO stuck high: R1 timeout after NCR_MAX bytes.
    clear_stream();
    run_cmd("cmd17_to", 6'd17, 32'h00000200, 1'b1, 7'h2A);
    check_eq("cmd17_frame", 64'(got_frame), 64'({2'b01, 6'd17, 32'h00000200, 7'h2A, 1'b1}));
    check_eq("cmd17_r1", 64'({got_to, got_r1}), 64'h1FF);
    check_eq("cmd17_sck", 64'(got_rises), 64'd120);
    check_eq("cmd17_cs_low", 64'(got_cs_low), 64'd960);
    check_eq("cmd17_cs_at_rv", 64'(got_cs_rv), 64'd1);
    check_eq("cmd17_ext", 64'(got_ext), 64'h0);

    // No crc_rdy: abort 64 cycles after CRC_WAIT entry, no bus activity.
    run_cmd("crc_to", 6'd55, 32'h0, 1'b0, 7'h00);
    check_eq("crc_to_lat", 64'(got_lat), 64'd65);
    check_eq("crc_to_r1", 64'({got_to, got_r1}), 64'h1FF);
    check_eq("crc_to_sck", 64'(got_rises), 64'd0);
    check_eq("crc_to_cs_low", 64'(got_cs_low), 64'd0);

    // Reset in the middle of SEND.
    clear_stream();
    @(posedge clk); base = rise_cnt;
    @(negedge clk); cmd_valid = 1'b1; cmd_index = 6'd17; cmd_arg = 32'h1234;
    @(negedge clk); cmd_valid = 1'b0;
    n = 0;
    while ((rise_cnt - base) < 20 && n < 2000) begin
      @(negedge clk); n++;
      crc_rdy = (n == 2); crc_out = 7'h11;
    end
    crc_rdy = 1'b0;
    check_eq("mid_send_cs", 64'(spi_cs_n), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_pins", 64'({spi_cs_n, spi_sck, spi_mosi}), 64'b101);
    check_eq("mid_rst_ready", 64'({cmd_ready, busy}), 64'b10);
    rst = 1'b0;
    $display("txn mid_send_reset after %0d sck edges", rise_cnt - base);
    clear_stream(); set_byte(0, 8'hFF); set_byte(1, 8'h01);
    run_cmd("cmd0_again", 6'd0, 32'h0, 1'b1, 7'h4A);
    check_eq("again_frame", 64'(got_frame), 64'h400000000095);
    check_eq("again_r1", 64'({got_to, got_r1}), 64'h001);

    // CLK_DIV=1 instance: cmd_valid held, stray crc_rdy during the frame.
    @(negedge clk);
    cmd_valid_1 = 1'b1; cmd_index_1 = 6'd17; cmd_arg_1 = 32'h0; s = -1; n = 0;
    while (resp_valid_1 !== 1'b1 && n < 2000) begin
      @(negedge clk); n++;
      if (crc_start_1 && s < 0) s = n;
      crc_rdy_1 = (s >= 0 && n == s + 2) || (!spi_cs_n_1 && (n % 5 == 0));
      crc_out_1 = 7'h3C;
    end
    check_eq("fast_resp_valid", 64'(resp_valid_1), 64'd1);
    check_eq("fast_r1", 64'({resp_timeout_1, resp_r1_1}), 64'h1FF);
    check_eq("fast_cs_at_rv", 64'(spi_cs_n_1), 64'd1);
    cmd_valid_1 = 1'b0; crc_rdy_1 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("fast_starts", 64'(starts_1), 64'd1);
    check_eq("fast_sck", 64'(rise_cnt_1), 64'd72);
    check_eq("fast_cs_low", 64'(cs_low_1), 64'd144);
    $display("txn fast_cmd17 starts=%0d sck=%0d cs_low=%0d", starts_1, rise_cnt_1, cs_low_1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
